// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing definitions for the capture and display blocks:
//   - default 640x480@60 porch/sync/visible constants
//   - line_total() helper used to derive H_TOTAL / V_TOTAL
//   - counter width and the capture FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  // Width of the h/v position counters and of pix_x/pix_y.
  localparam int CNT_W = 10;

  // Total period (in clocks for a line, in lines for a frame).
  function automatic int line_total(input int visible, input int fp,
                                    input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = line_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = line_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/vga_sync_check.sv
// ---------------------------------------------------------------------------
// vga_sync_check
// Edge detection, position counter and period/width check for one sync axis.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sync_s1       sync line already registered once (S1)
//   advance       count enable (every clock for h, every line start for v)
//   check_en      allow timing errors to be flagged
//   assert_edge   S1 shows the first asserted sample
//   cnt_next      counter value that lines up with the S1 sample
//   err           combinational timing-violation flag
// ---------------------------------------------------------------------------
module vga_sync_check
  import vga_timing_pkg::*;
#(
  parameter int   TOTAL       = 800,
  parameter int   SYNC_W      = 96,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_s1,
  input  logic             advance,
  input  logic             check_en,
  output logic             assert_edge,
  output logic [CNT_W-1:0] cnt_next,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);

  logic             sync_s2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             deassert_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s2_reg <= ~SYNC_ACTIVE;
      cnt_reg     <= '0;
    end else begin
      sync_s2_reg <= sync_s1;
      cnt_reg     <= cnt_next;
    end
  end

  assign assert_edge   = (sync_s1 == SYNC_ACTIVE) && (sync_s2_reg != SYNC_ACTIVE);
  assign deassert_edge = (sync_s1 != SYNC_ACTIVE) && (sync_s2_reg == SYNC_ACTIVE);

  // The assertion edge restarts the count and wins over an advance in the
  // same cycle; the counter saturates rather than wrapping on lost sync.
  always_comb begin
    cnt_next = cnt_reg;
    if (assert_edge) begin
      cnt_next = '0;
    end else if (advance && (cnt_reg != CNT_SAT)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // cnt_reg still holds the position of the sample before the edge, so a
  // correct period ends at TOTAL-1 and a correct pulse at SYNC_W-1.
  assign err = check_en &&
               ((assert_edge   && (cnt_reg != LAST_CNT)) ||
                (deassert_edge && (cnt_reg != SYNC_LAST)));

endmodule

// File: rtl/vga_capture.sv
// ---------------------------------------------------------------------------
// vga_capture
// Locks onto an incoming VGA stream, checks its timing and emits the
// coordinates and colour of every visible pixel.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   in_r/in_g/in_b      incoming colour bits
//   h_sync/v_sync       incoming sync lines (asserted level SYNC_ACTIVE)
//   pix_x/pix_y/pix_rgb captured pixel, updated only when pix_valid
//   pix_valid           outputs hold a visible pixel (2 clocks after pins)
//   frame_start         pulse alongside pixel (0,0)
//   locked              timing verified, capture enabled
//   h_err/v_err         one-cycle timing-violation pulses
//   frame_count         completed locked frames, wrapping
// ---------------------------------------------------------------------------
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_VISIBLE   = V_VISIBLE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_r,
  input  logic        in_g,
  input  logic        in_b,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = line_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BP + H_VISIBLE);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BP + V_VISIBLE);

  // S1 input registers
  logic [2:0] rgb_s1_reg;
  logic       hs_s1_reg;
  logic       vs_s1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1_reg <= '0;
      hs_s1_reg  <= ~SYNC_ACTIVE;
      vs_s1_reg  <= ~SYNC_ACTIVE;
    end else begin
      rgb_s1_reg <= {in_r, in_g, in_b};
      hs_s1_reg  <= h_sync;
      vs_s1_reg  <= v_sync;
    end
  end

  // Axis 0 = horizontal, axis 1 = vertical (advances on line starts).
  cap_state_t                 state_reg, state_next;
  logic [1:0]                 sync_s1;
  logic [1:0]                 advance;
  logic [1:0]                 edge_now;
  logic [1:0]                 err_now;
  logic [1:0][CNT_W-1:0]      cnt_next;
  logic                       check_en;

  assign sync_s1  = {vs_s1_reg, hs_s1_reg};
  assign advance  = {edge_now[0], 1'b1};
  // Counters are not yet aligned while searching, so no errors there.
  assign check_en = (state_reg != ST_SEARCH);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int TOTAL  = (gi == 0) ? H_TOTAL : V_TOTAL;
      localparam int SYNC_W = (gi == 0) ? H_SYNC  : V_SYNC;
      vga_sync_check #(
        .TOTAL       (TOTAL),
        .SYNC_W      (SYNC_W),
        .SYNC_ACTIVE (SYNC_ACTIVE)
      ) u_check (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_s1     (sync_s1[gi]),
        .advance     (advance[gi]),
        .check_en    (check_en),
        .assert_edge (edge_now[gi]),
        .cnt_next    (cnt_next[gi]),
        .err         (err_now[gi])
      );
    end
  endgenerate

  logic v_edge;
  logic any_err;
  assign v_edge  = edge_now[1];
  assign any_err = |err_now;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_SEARCH:  if (v_edge) state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (any_err)     state_next = ST_SEARCH;
        else if (v_edge) state_next = ST_LOCKED;
      end
      ST_LOCKED:  if (any_err) state_next = ST_SEARCH;
      default:    state_next = ST_SEARCH;
    endcase
  end

  // cnt_next is the position of the pixel now in S1, which keeps colour
  // and coordinates together at two clocks from the pins.
  logic             active;
  logic             capture;
  logic [CNT_W-1:0] x_off;
  logic [CNT_W-1:0] y_off;

  assign active  = (cnt_next[0] >= H_ACT_LO) && (cnt_next[0] < H_ACT_HI) &&
                   (cnt_next[1] >= V_ACT_LO) && (cnt_next[1] < V_ACT_HI);
  assign capture = active && (state_reg == ST_LOCKED);
  assign x_off   = cnt_next[0] - H_ACT_LO;
  assign y_off   = cnt_next[1] - V_ACT_LO;

  logic [9:0]  pix_x_reg;
  logic [9:0]  pix_y_reg;
  logic [2:0]  pix_rgb_reg;
  logic        pix_valid_reg;
  logic        frame_start_reg;
  logic        h_err_reg;
  logic        v_err_reg;
  logic [15:0] frame_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_SEARCH;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      pix_rgb_reg     <= '0;
      pix_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      h_err_reg       <= 1'b0;
      v_err_reg       <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pix_valid_reg   <= capture;
      frame_start_reg <= capture && (x_off == '0) && (y_off == '0);
      h_err_reg       <= err_now[0];
      v_err_reg       <= err_now[1];
      if (capture) begin
        pix_x_reg   <= x_off;
        pix_y_reg   <= y_off;
        pix_rgb_reg <= rgb_s1_reg;
      end
      if ((state_reg == ST_LOCKED) && v_edge && !any_err) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign pix_rgb     = pix_rgb_reg;
  assign pix_valid   = pix_valid_reg;
  assign frame_start = frame_start_reg;
  assign locked      = (state_reg == ST_LOCKED);
  assign h_err       = h_err_reg;
  assign v_err       = v_err_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_capture
// Directed bench for vga_capture using a reduced raster:
//   line  = 3 sync + 2 back porch + 8 visible + 2 front porch = 15 clocks
//   frame = 2 sync + 2 back porch + 4 visible + 1 front porch = 9 lines
// ---------------------------------------------------------------------------
module tb_vga_capture;

  localparam int H_VIS  = 8;
  localparam int H_FP   = 2;
  localparam int H_SYN  = 3;
  localparam int H_BP   = 2;
  localparam int V_VIS  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYN  = 2;
  localparam int V_BP   = 2;
  localparam int H_TOT  = H_VIS + H_FP + H_SYN + H_BP;   // 15
  localparam int V_TOT  = V_VIS + V_FP + V_SYN + V_BP;   // 9
  localparam int H_ST   = H_SYN + H_BP;                  // 5
  localparam int V_ST   = V_SYN + V_BP;                  // 4
  localparam int PIX_PER_FRAME = H_VIS * V_VIS;          // 32
  localparam logic [2:0] FIXED_RGB = 3'b101;

  logic        clk;
  logic        rst_n;
  logic        in_r, in_g, in_b;
  logic        h_sync, v_sync;
  logic [9:0]  pix_x, pix_y;
  logic [2:0]  pix_rgb;
  logic        pix_valid, frame_start, locked, h_err, v_err;
  logic [15:0] frame_count;

  vga_capture #(
    .H_VISIBLE   (H_VIS),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYN),
    .H_BP        (H_BP),
    .V_VISIBLE   (V_VIS),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYN),
    .V_BP        (V_BP),
    .SYNC_ACTIVE (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .h_err       (h_err),
    .v_err       (v_err),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec;
  int   n_miss;
  int   cyc;
  int   drv00;
  int   lock_rise_iter;
  int   unlock_iter;
  int   herr_iter;
  int   verr_iter;
  int   frm_valid;
  int   frm_herr;
  int   frm_verr;
  int   exp_x;
  int   exp_y;
  int   color_mode;
  int   f_start;
  logic locked_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic logic [2:0] pat(input int x, input int y);
    int t;
    t = x * 5 + y * 3 + 1;
    return t[2:0];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_pix_x"},       pix_x,       0);
    chk({tag, "_pix_y"},       pix_y,       0);
    chk({tag, "_pix_rgb"},     pix_rgb,     0);
    chk({tag, "_pix_valid"},   pix_valid,   0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_locked"},      locked,      0);
    chk({tag, "_h_err"},       h_err,       0);
    chk({tag, "_v_err"},       v_err,       0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  // Per-cycle observation; expected pixels walk (0,0)..(7,3) in raster order.
  task automatic observe();
    logic [2:0] want_rgb;
    if (h_err) begin frm_herr++; herr_iter = cyc; end
    if (v_err) begin frm_verr++; verr_iter = cyc; end
    if (locked && !locked_prev) lock_rise_iter = cyc;
    if (!locked && locked_prev) unlock_iter = cyc;
    locked_prev = locked;
    if (pix_valid) begin
      frm_valid++;
      want_rgb = (color_mode != 0) ? pat(exp_x, exp_y) : FIXED_RGB;
      chk("pix_x", pix_x, exp_x);
      chk("pix_y", pix_y, exp_y);
      chk("pix_rgb", pix_rgb, want_rgb);
      chk("frame_start", frame_start, (exp_x == 0) && (exp_y == 0));
      if (frame_start) chk("fs_latency", cyc - drv00, 1);
      exp_x++;
      if (exp_x == H_VIS) begin
        exp_x = 0;
        exp_y++;
        if (exp_y == V_VIS) exp_y = 0;
      end
    end else if (frame_start) begin
      chk("frame_start_idle", frame_start, 0);
    end
    if (!locked) begin
      exp_x = 0;
      exp_y = 0;
    end
  endtask

  task automatic tick(input logic hs, input logic vs, input logic [2:0] c, input bit first_px);
    h_sync = hs;
    v_sync = vs;
    in_r   = c[2];
    in_g   = c[1];
    in_b   = c[0];
    if (first_px) drv00 = cyc;
    @(posedge clk);
    #1;
    observe();
    cyc++;
  endtask

  task automatic new_frame();
    frm_valid = 0;
    frm_herr  = 0;
    frm_verr  = 0;
  endtask

  // vs_lines: v_sync width; short_y: line one clock short; rst_y/rst_x: reset pulse point.
  task automatic send_frame(input int vs_lines, input int short_y, input int rst_y, input int rst_x);
    for (int y = 0; y < V_TOT; y++) begin
      int len;
      len = (y == short_y) ? H_TOT - 1 : H_TOT;
      for (int x = 0; x < len; x++) begin
        logic       act;
        logic [2:0] c;
        logic       hs, vs;
        act = (x >= H_ST) && (x < H_ST + H_VIS) && (y >= V_ST) && (y < V_ST + V_VIS);
        c   = act ? ((color_mode != 0) ? pat(x - H_ST, y - V_ST) : FIXED_RGB) : 3'b000;
        hs  = (x < H_SYN) ? 1'b0 : 1'b1;
        vs  = (y < vs_lines) ? 1'b0 : 1'b1;
        if (y == rst_y && x == rst_x) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("rst_mid");
          frm_valid = 0;
          tick(hs, vs, c, act && x == H_ST && y == V_ST);
          rst_n = 1'b1;
        end else begin
          tick(hs, vs, c, act && x == H_ST && y == V_ST);
        end
      end
    end
  endtask

  task automatic frame_stats(input string tag, input int want_valid, input logic want_locked,
                             input int want_herr, input int want_verr, input int want_fc);
    chk({tag, "_valid"},  frm_valid,   want_valid);
    chk({tag, "_locked"}, locked,      want_locked);
    chk({tag, "_h_err"},  frm_herr,    want_herr);
    chk({tag, "_v_err"},  frm_verr,    want_verr);
    chk({tag, "_fcount"}, frame_count, want_fc);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; cyc = 0; drv00 = -100;
    lock_rise_iter = -1; unlock_iter = -1; herr_iter = -2; verr_iter = -2;
    exp_x = 0; exp_y = 0; color_mode = 0; locked_prev = 1'b0;
    rst_n = 1'b0; h_sync = 1'b1; v_sync = 1'b1; in_r = 1'b0; in_g = 1'b0; in_b = 1'b0;
    new_frame();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) tick(1'b1, 1'b1, 3'b000, 1'b0);

    // First v_sync assertion: SEARCH -> MEASURE only.
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f1", 0, 1'b0, 0, 0, 0);

    // Second v_sync assertion: locks one clock after the pin.
    new_frame(); f_start = cyc; send_frame(V_SYN, -1, -1, -1);
    chk("f2_lock_latency", lock_rise_iter - f_start, 1);
    frame_stats("f2", PIX_PER_FRAME, 1'b1, 0, 0, 0);
    chk("hold_pix_x", pix_x, H_VIS - 1);
    chk("hold_pix_y", pix_y, V_VIS - 1);
    chk("hold_pix_rgb", pix_rgb, FIXED_RGB);
    chk("hold_valid", pix_valid, 0);

    // Per-pixel colour pattern.
    color_mode = 1;
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f3", PIX_PER_FRAME, 1'b1, 0, 0, 1);

    // Line 5 one clock short: error at start of line 6, lines 4..5 captured.
    color_mode = 0;
    new_frame(); send_frame(V_SYN, 5, -1, -1);
    frame_stats("f4_short", 2 * H_VIS, 1'b0, 1, 0, 2);
    chk("f4_unlock_with_herr", unlock_iter - herr_iter, 0);

    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f5_measure", 0, 1'b0, 0, 0, 2);
    new_frame(); f_start = cyc; send_frame(V_SYN, -1, -1, -1);
    chk("f6_relock_latency", lock_rise_iter - f_start, 1);
    frame_stats("f6_relock", PIX_PER_FRAME, 1'b1, 0, 0, 2);

    // v_sync held for 3 lines: frame start counted, then v_err at line 3.
    new_frame(); send_frame(3, -1, -1, -1);
    frame_stats("f7_vlong", 0, 1'b0, 0, 1, 3);
    chk("f7_unlock_with_verr", unlock_iter - verr_iter, 0);

    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f8_measure", 0, 1'b0, 0, 0, 3);
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f9_relock", PIX_PER_FRAME, 1'b1, 0, 0, 3);

    // Reset pulse in the middle of visible line 5.
    color_mode = 1;
    new_frame(); send_frame(V_SYN, -1, 5, 7);
    frame_stats("f10_after_rst", 0, 1'b0, 0, 0, 0);
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f11_measure", 0, 1'b0, 0, 0, 0);
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f12_relock", PIX_PER_FRAME, 1'b1, 0, 0, 0);

    // Preload near the top of the range and watch the wrap.
    dut.frame_count_reg <= 16'hfffe;
    #1;
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f13_pre_wrap", PIX_PER_FRAME, 1'b1, 0, 0, 16'hffff);
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f14_wrap", PIX_PER_FRAME, 1'b1, 0, 0, 0);
    new_frame(); send_frame(V_SYN, -1, -1, -1);
    frame_stats("f15_post_wrap", PIX_PER_FRAME, 1'b1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
